// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator symbol sequencer.
//   - symbol codes arriving from the recogniser
//   - operator encodings expected by the combinational calculator
//   - sequencer state encoding
//   - small symbol classification helpers
package calc_pkg;

   localparam logic [3:0] SYM_ADD = 4'd10;
   localparam logic [3:0] SYM_SUB = 4'd11;
   localparam logic [3:0] SYM_MUL = 4'd12;
   localparam logic [3:0] SYM_EQ  = 4'd13;
   localparam logic [3:0] SYM_CLR = 4'd14;

   localparam logic [3:0] OPE_ADD = 4'd0;
   localparam logic [3:0] OPE_SUB = 4'd1;
   localparam logic [3:0] OPE_MUL = 4'd2;

   typedef enum logic [2:0] {
      S_A      = 3'd0,
      S_OP     = 3'd1,
      S_B      = 3'd2,
      S_EQ     = 3'd3,
      S_SETTLE = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   function automatic logic is_digit_sym(input logic [3:0] code);
      return code <= 4'd9;
   endfunction

   function automatic logic is_oper_sym(input logic [3:0] code);
      return (code == SYM_ADD) || (code == SYM_SUB) || (code == SYM_MUL);
   endfunction

endpackage

// File: rtl/calc_sequencer.sv
// calc_sequencer: assembles first operand, operator and second operand from a
// stream of recognised symbols, holds them stable on the calculator inputs for
// SETTLE_CYCLES cycles after '=', then latches the calculator's tens/units
// result for the display with a one-cycle valid strobe.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   sym_valid, sym_code       symbol stream (0-9 digit, 10 +, 11 -, 12 *,
//                             13 =, 14 clear, 15 illegal)
//   sym_ready                 symbol accepted this cycle when high with valid
//   index_fir_Num/sec_Num/ope operands and operator to the calculator
//   result_d, result_u        calculator tens/units result
//   disp_d, disp_u            latched result for display
//   disp_valid                one-cycle strobe when disp_d/disp_u update
//   underflow                 last subtraction had first < second
//   err                       sticky illegal/out-of-order symbol flag
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sym_valid,
   input  logic [3:0] sym_code,
   output logic       sym_ready,
   output logic [3:0] index_fir_Num,
   output logic [3:0] index_sec_Num,
   output logic [3:0] index_ope,
   input  logic [3:0] result_d,
   input  logic [3:0] result_u,
   output logic [3:0] disp_d,
   output logic [3:0] disp_u,
   output logic       disp_valid,
   output logic       underflow,
   output logic       err
);

   // Counter is loaded with SETTLE_CYCLES-1 so the sample happens on the
   // SETTLE_CYCLES-th cycle spent in S_SETTLE.
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t     state_reg, state_next;
   logic [3:0] cnt_reg, cnt_next;
   logic [3:0] fir_reg, fir_next;
   logic [3:0] sec_reg, sec_next;
   logic [3:0] ope_reg, ope_next;
   logic [3:0] disp_d_reg, disp_d_next;
   logic [3:0] disp_u_reg, disp_u_next;
   logic       disp_valid_reg, disp_valid_next;
   logic       underflow_reg, underflow_next;
   logic       err_reg, err_next;

   logic accept;
   logic is_digit;
   logic is_oper;

   assign sym_ready = (state_reg != S_SETTLE);
   assign accept    = sym_valid && sym_ready;
   assign is_digit  = is_digit_sym(sym_code);
   assign is_oper   = is_oper_sym(sym_code);

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      fir_next        = fir_reg;
      sec_next        = sec_reg;
      ope_next        = ope_reg;
      disp_d_next     = disp_d_reg;
      disp_u_next     = disp_u_reg;
      underflow_next  = underflow_reg;
      err_next        = err_reg;
      disp_valid_next = 1'b0;

      if (state_reg == S_SETTLE) begin
         if (cnt_reg == 4'd0) begin
            disp_d_next     = result_d;
            disp_u_next     = result_u;
            // The calculator clamps a negative difference to 0; flag it here.
            underflow_next  = (ope_reg == OPE_SUB) && (fir_reg < sec_reg);
            disp_valid_next = 1'b1;
            state_next      = S_DONE;
         end else begin
            cnt_next = cnt_reg - 4'd1;
         end
      end else if (accept) begin
         if (sym_code == SYM_CLR) begin
            state_next     = S_A;
            fir_next       = 4'd0;
            sec_next       = 4'd0;
            ope_next       = OPE_ADD;
            disp_d_next    = 4'd0;
            disp_u_next    = 4'd0;
            underflow_next = 1'b0;
            err_next       = 1'b0;
         end else begin
            case (state_reg)
               S_A: begin
                  if (is_digit) begin
                     fir_next   = sym_code;
                     state_next = S_OP;
                  end else begin
                     err_next = 1'b1;
                  end
               end
               S_OP: begin
                  if (is_oper) begin
                     ope_next   = sym_code - SYM_ADD;
                     state_next = S_B;
                  end else if (is_digit) begin
                     fir_next = sym_code;
                  end else begin
                     err_next = 1'b1;
                  end
               end
               S_B: begin
                  if (is_digit) begin
                     sec_next   = sym_code;
                     state_next = S_EQ;
                  end else begin
                     err_next = 1'b1;
                  end
               end
               S_EQ: begin
                  if (sym_code == SYM_EQ) begin
                     cnt_next   = SETTLE_LOAD;
                     state_next = S_SETTLE;
                  end else if (is_digit) begin
                     sec_next = sym_code;
                  end else if (is_oper) begin
                     ope_next   = sym_code - SYM_ADD;
                     state_next = S_B;
                  end else begin
                     err_next = 1'b1;
                  end
               end
               S_DONE: begin
                  if (is_digit) begin
                     // New calculation; display stays until the next '='.
                     fir_next   = sym_code;
                     sec_next   = 4'd0;
                     state_next = S_OP;
                  end else if (sym_code == SYM_EQ) begin
                     cnt_next   = SETTLE_LOAD;
                     state_next = S_SETTLE;
                  end else begin
                     err_next = 1'b1;
                  end
               end
               default: state_next = S_A;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= S_A;
         cnt_reg        <= 4'd0;
         fir_reg        <= 4'd0;
         sec_reg        <= 4'd0;
         ope_reg        <= 4'd0;
         disp_d_reg     <= 4'd0;
         disp_u_reg     <= 4'd0;
         disp_valid_reg <= 1'b0;
         underflow_reg  <= 1'b0;
         err_reg        <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         fir_reg        <= fir_next;
         sec_reg        <= sec_next;
         ope_reg        <= ope_next;
         disp_d_reg     <= disp_d_next;
         disp_u_reg     <= disp_u_next;
         disp_valid_reg <= disp_valid_next;
         underflow_reg  <= underflow_next;
         err_reg        <= err_next;
      end
   end

   assign index_fir_Num = fir_reg;
   assign index_sec_Num = sec_reg;
   assign index_ope     = ope_reg;
   assign disp_d        = disp_d_reg;
   assign disp_u        = disp_u_reg;
   assign disp_valid    = disp_valid_reg;
   assign underflow     = underflow_reg;
   assign err           = err_reg;

endmodule
